// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the openMIPS pipeline control unit.
// Holds the flush FSM state encoding and the pipeline stage index map.
package pipe_ctrl_pkg;

  typedef enum logic {
    PC_IDLE  = 1'b0,
    PC_FLUSH = 1'b1
  } state_e;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int DEF_NUM_STAGES = 6;
  localparam int DEF_PC_W       = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 6,
  parameter int PC_W       = 32
);

  logic [NUM_STAGES-1:0] stallreq;
  logic                  flush_req;
  logic [PC_W-1:0]       flush_pc;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [PC_W-1:0]       new_pc;
  logic                  stall_timeout;
  logic [31:0]           stall_cycles;

  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_stall_merge.sv
// Suffix-OR of per-stage stall requests: a stalling stage also holds every
// register upstream of it.
module stall_merge #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] hold
);

  logic acc;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    acc  = 1'b0;
    hold = '0;
    for (int i = N - 1; i >= 0; i--) begin
      acc     = acc | req[i];
      hold[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, flush/redirect FSM and consecutive-stall watchdog.
// Define PIPE_CTRL_PERF_CNT_EN to build the saturating stall_cycles counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = DEF_NUM_STAGES,
  parameter int PC_W          = DEF_PC_W,
  parameter int TIMEOUT_W     = 8,
  parameter int STALL_TIMEOUT = 200   // legal range 1 .. 2**TIMEOUT_W-1
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(STALL_TIMEOUT);

  state_e                state_q, state_d;
  logic [PC_W-1:0]       pc_q;
  logic [TIMEOUT_W-1:0]  run_q;
  logic [NUM_STAGES-1:0] merged;
  logic [NUM_STAGES-1:0] stall_w;
  logic                  flush_w;
  logic [PC_W-1:0]       new_pc_w;
  logic                  counting;

  stall_merge #(.N(NUM_STAGES)) u_stall_merge (
    .req  (bus.stallreq),
    .hold (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      // Any accepted request (first or back-to-back) retargets the redirect.
      if (bus.flush_req) pc_q <= bus.flush_pc;
    end
  end

  always_comb begin
    state_d  = state_q;
    flush_w  = 1'b0;
    new_pc_w = '0;
    stall_w  = merged;
    unique case (state_q)
      PC_IDLE: begin
        if (bus.flush_req) state_d = PC_FLUSH;
      end
      PC_FLUSH: begin
        flush_w  = 1'b1;
        new_pc_w = pc_q;
        stall_w  = '0;
        state_d  = bus.flush_req ? PC_FLUSH : PC_IDLE;
      end
      default: state_d = PC_IDLE;
    endcase
    if (rst) stall_w = '0;
  end

  // Watchdog run length; saturates so the timeout level holds until release.
  assign counting = stall_w[STG_PC] & ~flush_w;

  always_ff @(posedge clk) begin
    if (rst || !counting) begin
      run_q <= '0;
    end else if (run_q != TIMEOUT_VAL) begin
      run_q <= run_q + 1'b1;
    end
  end

  assign bus.stall         = stall_w;
  assign bus.flush         = flush_w;
  assign bus.new_pc        = new_pc_w;
  assign bus.stall_timeout = (run_q == TIMEOUT_VAL) & stall_w[STG_PC];

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (counting && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.stall_cycles = perf_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule
